// File: rtl/hw_regs_pkg.sv
// hw_regs_pkg
//   Types and helpers shared by the hardware control register block and the
//   write coalescer that feeds it.
//   - hw_state_e : coalescer state encoding
//   - lane_of()  : byte offset -> byte lane (big-endian placement)
package hw_regs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2
    } hw_state_e;

    // Offset 0 lands in the most significant lane; the register file decodes
    // lanes the same way, so both sides must call this one function.
    function automatic int lane_of(input int offset, input int n);
        return (n - 1) ^ offset;
    endfunction

endpackage

// File: rtl/hwreg_lane_merge.sv
// hwreg_lane_merge
//   Purely combinational merge of one byte into a line buffer.
//   Ports:
//     line_data   in  DATA_W   current line contents
//     line_mask   in  N        current byte-lane enables
//     offset      in  OFS_W    byte offset within the line
//     byte_in     in  8        byte to merge (overwrites an already-set lane)
//     merged_data out DATA_W   line contents with the byte placed
//     merged_mask out N        lane enables including the new lane
//     full        out 1        all lanes enabled after the merge
module hwreg_lane_merge
    import hw_regs_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int N      = DATA_W / 8,
    parameter int OFS_W  = ($clog2(N) == 0) ? 1 : $clog2(N)
) (
    input  logic [DATA_W-1:0] line_data,
    input  logic [N-1:0]      line_mask,
    input  logic [OFS_W-1:0]  offset,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] merged_data,
    output logic [N-1:0]      merged_mask,
    output logic              full
);

    int lane_sel;

    always_comb begin
        lane_sel    = lane_of(int'(offset), N);
        merged_data = line_data;
        merged_mask = line_mask;
        for (int k = 0; k < N; k++) begin
            if (k == lane_sel) begin
                merged_data[k*8 +: 8] = byte_in;
                merged_mask[k]        = 1'b1;
            end
        end
    end

    assign full = &merged_mask;

endmodule

// File: rtl/hw_regs_write_coalescer.sv
// hw_regs_write_coalescer
//   Packs single-byte CPU writes into masked line-wide writes for the HW
//   control register file. A line is emitted when full, when a write targets
//   another line, on FLUSH, or after FLUSH_TIMEOUT idle cycles.
//   Ports:
//     CLK, RESET_n          clock, async active-low reset
//     WR_REQ/WR_ADDR/WR_DATA byte write request from the bus interface
//     WR_READY              request accepted when WR_REQ && WR_READY (comb)
//     FLUSH                 force emit of the pending line
//     WE                    one-cycle write strobe to the register file
//     ADDR_OUT              line address (low L bits zero)
//     DATA_OUT / WMASK_OUT  line data and byte-lane enables
//     BUSY                  state is not IDLE
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | buffer empty, ready for any write
//   FILL  | buffer holds >=1 byte of line `tag`; idle timer running
//   EMIT  | WE high this cycle with the captured line; buffer already empty
module hw_regs_write_coalescer
    import hw_regs_pkg::*;
#(
    parameter int PORT_ADDR_SIZE  = 19,
    parameter int PORT_CACHE_BITS = 128,
    parameter int FLUSH_TIMEOUT   = 16
) (
    input  logic                       CLK,
    input  logic                       RESET_n,
    input  logic                       WR_REQ,
    input  logic [PORT_ADDR_SIZE-1:0]  WR_ADDR,
    input  logic [7:0]                 WR_DATA,
    output logic                       WR_READY,
    input  logic                       FLUSH,
    output logic                       WE,
    output logic [PORT_ADDR_SIZE-1:0]  ADDR_OUT,
    output logic [PORT_CACHE_BITS-1:0] DATA_OUT,
    output logic [PORT_CACHE_BITS/8-1:0] WMASK_OUT,
    output logic                       BUSY
);

    localparam int N     = PORT_CACHE_BITS / 8;
    localparam int L     = $clog2(N);
    localparam int OFS_W = (L == 0) ? 1 : L;
    localparam int TW    = $clog2(FLUSH_TIMEOUT) + 1;

    localparam logic [TW-1:0]             T_LAST   = TW'(FLUSH_TIMEOUT - 1);
    localparam logic [PORT_ADDR_SIZE-1:0] LOW_MASK = PORT_ADDR_SIZE'(N - 1);

    hw_state_e                  state;
    logic [PORT_ADDR_SIZE-1:0]  tag;
    logic [PORT_CACHE_BITS-1:0] buf_data;
    logic [N-1:0]               buf_mask;
    logic [TW-1:0]              timer;

    logic [PORT_ADDR_SIZE-1:0]  line_addr;
    logic [OFS_W-1:0]           offset;
    logic                       same_line;
    logic                       accept;
    logic                       go_emit;
    logic [PORT_CACHE_BITS-1:0] base_data;
    logic [N-1:0]               base_mask;
    logic [PORT_CACHE_BITS-1:0] merged_data;
    logic [N-1:0]               merged_mask;
    logic                       full;
    logic [PORT_ADDR_SIZE-1:0]  emit_addr;
    logic [PORT_CACHE_BITS-1:0] emit_data;
    logic [N-1:0]               emit_mask;

    assign line_addr = WR_ADDR & ~LOW_MASK;
    assign offset    = WR_ADDR[OFS_W-1:0] & OFS_W'(N - 1);
    assign same_line = (line_addr == tag);

    // Only a different-line request in FILL stalls; the master holds it
    // through the EMIT cycle, where it is accepted.
    assign WR_READY = RESET_n && !((state == FILL) && WR_REQ && !same_line);
    assign accept   = WR_REQ && WR_READY;

    // Outside FILL the buffer is already empty, so a new line starts from zero.
    assign base_data = (state == FILL) ? buf_data : '0;
    assign base_mask = (state == FILL) ? buf_mask : '0;

    hwreg_lane_merge #(
        .DATA_W (PORT_CACHE_BITS),
        .N      (N),
        .OFS_W  (OFS_W)
    ) u_merge (
        .line_data   (base_data),
        .line_mask   (base_mask),
        .offset      (offset),
        .byte_in     (WR_DATA),
        .merged_data (merged_data),
        .merged_mask (merged_mask),
        .full        (full)
    );

    always_comb begin
        go_emit = 1'b0;
        if (state == FILL) begin
            if (accept) begin
                go_emit = full || FLUSH;
            end else begin
                go_emit = WR_REQ || FLUSH || (timer == T_LAST);
            end
        end else begin
            go_emit = accept && full;
        end
    end

    // A same-cycle accepted byte is part of the emitted line.
    assign emit_addr = (state == FILL) ? tag : line_addr;
    assign emit_data = accept ? merged_data : buf_data;
    assign emit_mask = accept ? merged_mask : buf_mask;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state     <= IDLE;
            tag       <= '0;
            buf_data  <= '0;
            buf_mask  <= '0;
            timer     <= '0;
            WE        <= 1'b0;
            ADDR_OUT  <= '0;
            DATA_OUT  <= '0;
            WMASK_OUT <= '0;
            BUSY      <= 1'b0;
        end else begin
            WE <= go_emit;
            if (go_emit) begin
                state     <= EMIT;
                BUSY      <= 1'b1;
                ADDR_OUT  <= emit_addr;
                DATA_OUT  <= emit_data;
                WMASK_OUT <= emit_mask;
                buf_data  <= '0;
                buf_mask  <= '0;
                timer     <= '0;
            end else if (accept) begin
                state     <= FILL;
                BUSY      <= 1'b1;
                tag       <= line_addr;
                buf_data  <= merged_data;
                buf_mask  <= merged_mask;
                timer     <= '0;
            end else if (state == FILL) begin
                // Cannot pass T_LAST: reaching it forces go_emit above.
                timer <= timer + 1'b1;
            end else begin
                state <= IDLE;
                BUSY  <= 1'b0;
                timer <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hw_regs_write_coalescer.sv
// tb_hw_regs_write_coalescer
//   Directed stimulus against hw_regs_write_coalescer with a byte-array line
//   model checked every cycle, plus literal expectations on captured writes.
module tb_hw_regs_write_coalescer;

    localparam int AW = 19;
    localparam int DW = 128;
    localparam int N  = 16;
    localparam int FT = 16;

    logic          CLK;
    logic          RESET_n;
    logic          WR_REQ;
    logic [AW-1:0] WR_ADDR;
    logic [7:0]    WR_DATA;
    logic          WR_READY;
    logic          FLUSH;
    logic          WE;
    logic [AW-1:0] ADDR_OUT;
    logic [DW-1:0] DATA_OUT;
    logic [N-1:0]  WMASK_OUT;
    logic          BUSY;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int            c;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [N-1:0]  m;
    } we_rec_t;
    we_rec_t we_q[$];

    // Model: pending bytes indexed by byte offset within the line.
    bit            m_pend;
    logic [AW-1:0] m_line;
    logic [7:0]    m_bytes[N];
    bit            m_valid[N];
    int            m_idle;
    logic          e_we;
    logic          e_busy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [N-1:0]  e_mask;

    hw_regs_write_coalescer #(
        .PORT_ADDR_SIZE  (AW),
        .PORT_CACHE_BITS (DW),
        .FLUSH_TIMEOUT   (FT)
    ) dut (
        .CLK       (CLK),
        .RESET_n   (RESET_n),
        .WR_REQ    (WR_REQ),
        .WR_ADDR   (WR_ADDR),
        .WR_DATA   (WR_DATA),
        .WR_READY  (WR_READY),
        .FLUSH     (FLUSH),
        .WE        (WE),
        .ADDR_OUT  (ADDR_OUT),
        .DATA_OUT  (DATA_OUT),
        .WMASK_OUT (WMASK_OUT),
        .BUSY      (BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_ready();
        return (RESET_n === 1'b1) &&
               !(m_pend && WR_REQ && ({WR_ADDR[AW-1:4], 4'b0} != m_line));
    endfunction

    task automatic model_reset();
        m_pend = 0;
        m_line = '0;
        m_idle = 0;
        for (int o = 0; o < N; o++) begin
            m_bytes[o] = 8'h00;
            m_valid[o] = 0;
        end
        e_we   = 1'b0;
        e_busy = 1'b0;
        e_addr = '0;
        e_data = '0;
        e_mask = '0;
    endtask

    task automatic model_step();
        bit was_pend;
        bit acc;
        bit emit;
        bit all_set;
        int o;
        was_pend = m_pend;
        acc      = WR_REQ && model_ready();
        emit     = 0;
        o        = int'(WR_ADDR[3:0]);
        if (acc) begin
            if (!was_pend) begin
                for (int i = 0; i < N; i++) m_valid[i] = 0;
                m_line = {WR_ADDR[AW-1:4], 4'b0};
                m_pend = 1;
            end
            m_bytes[o] = WR_DATA;
            m_valid[o] = 1;
            m_idle     = 0;
            all_set    = 1;
            for (int i = 0; i < N; i++) if (!m_valid[i]) all_set = 0;
            if (all_set || (FLUSH && was_pend)) emit = 1;
        end else if (was_pend) begin
            if (WR_REQ || FLUSH) begin
                emit = 1;
            end else begin
                m_idle++;
                if (m_idle == FT) emit = 1;
            end
        end
        e_we = emit;
        if (emit) begin
            e_addr = m_line;
            e_data = '0;
            e_mask = '0;
            // Byte at offset i occupies the i-th byte counting from the top.
            for (int i = 0; i < N; i++) begin
                if (m_valid[i]) begin
                    e_data[DW-1-8*i -: 8] = m_bytes[i];
                    e_mask[N-1-i]         = 1'b1;
                end
            end
            m_pend = 0;
        end
        e_busy = m_pend || emit;
    endtask

    initial forever begin
        @(posedge CLK or negedge RESET_n);
        if (!RESET_n) model_reset();
        else model_step();
    end

    // Per-cycle compare against the model, plus a log of observed writes.
    initial begin
        @(posedge CLK);
        forever begin
            @(negedge CLK);
            check("we", DW'(WE), DW'(e_we));
            check("busy", DW'(BUSY), DW'(e_busy));
            check("addr_out", DW'(ADDR_OUT), DW'(e_addr));
            check("data_out", DATA_OUT, e_data);
            check("wmask_out", DW'(WMASK_OUT), DW'(e_mask));
            if (WR_REQ || !RESET_n) check("wr_ready", DW'(WR_READY), DW'(model_ready()));
            if (WE === 1'b1) we_q.push_back('{cyc, ADDR_OUT, DATA_OUT, WMASK_OUT});
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Holds the request until WR_READY, as the bus master does.
    task automatic write_byte(input logic [AW-1:0] a, input logic [7:0] d,
                              output int acc_c, output int stalls);
        bit r;
        WR_REQ  = 1'b1;
        WR_ADDR = a;
        WR_DATA = d;
        stalls  = 0;
        acc_c   = -1;
        for (int b = 0; b < 50; b++) begin
            @(negedge CLK);
            r = WR_READY;
            if (r) acc_c = cyc;
            @(posedge CLK);
            #1;
            if (r) break;
            stalls++;
        end
        WR_REQ = 1'b0;
        if (acc_c < 0) check("write_accept_timeout", DW'(0), DW'(1));
    endtask

    task automatic pulse_flush(output int fc);
        FLUSH = 1'b1;
        fc    = cyc;
        @(posedge CLK);
        #1;
        FLUSH = 1'b0;
    endtask

    task automatic timeout_case(input string tag);
        int t;
        int s;
        we_q.delete();
        write_byte(19'h00012, 8'hA5, t, s);
        idle(FT + 4);
        check({tag, "_we_count"}, DW'(we_q.size()), DW'(1));
        if (we_q.size() > 0) begin
            check({tag, "_latency"}, DW'(we_q[0].c - t), DW'(17));
            check({tag, "_addr"}, DW'(we_q[0].a), DW'(19'h00010));
            check({tag, "_mask"}, DW'(we_q[0].m), DW'(16'h2000));
            check({tag, "_data"}, we_q[0].d, 128'hA5 << 104);
        end
    endtask

    initial begin
        int t0, t1, t_first, t_last, s, stall_sum, fc;
        RESET_n = 1'b0;
        WR_REQ  = 1'b1;
        WR_ADDR = 19'h00012;
        WR_DATA = 8'h00;
        FLUSH   = 1'b0;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_we", DW'(WE), DW'(0));
        check("rst_busy", DW'(BUSY), DW'(0));
        check("rst_addr", DW'(ADDR_OUT), DW'(0));
        check("rst_data", DATA_OUT, DW'(0));
        check("rst_mask", DW'(WMASK_OUT), DW'(0));
        check("rst_ready", DW'(WR_READY), DW'(0));
        @(posedge CLK);
        #1;
        RESET_n = 1'b1;
        WR_REQ  = 1'b0;
        idle(2);

        timeout_case("timeout");

        we_q.delete();
        stall_sum = 0;
        t_first   = 0;
        t_last    = 0;
        for (int i = 0; i < N; i++) begin
            write_byte(19'h00100 + AW'(i), 8'(i), t_last, s);
            if (i == 0) t_first = t_last;
            stall_sum += s;
        end
        idle(3);
        check("full_stalls", DW'(stall_sum), DW'(0));
        check("full_span", DW'(t_last - t_first), DW'(15));
        check("full_we_count", DW'(we_q.size()), DW'(1));
        if (we_q.size() > 0) begin
            check("full_latency", DW'(we_q[0].c - t_last), DW'(1));
            check("full_addr", DW'(we_q[0].a), DW'(19'h00100));
            check("full_mask", DW'(we_q[0].m), DW'(16'hFFFF));
            check("full_data", we_q[0].d, 128'h000102030405060708090A0B0C0D0E0F);
        end

        we_q.delete();
        write_byte(19'h00020, 8'h11, t0, s);
        write_byte(19'h00030, 8'h22, t1, s);
        check("chg_stalls", DW'(s), DW'(1));
        idle(FT + 4);
        check("chg_we_count", DW'(we_q.size()), DW'(2));
        if (we_q.size() > 1) begin
            check("chg_first_cycle", DW'(we_q[0].c), DW'(t1));
            check("chg_first_addr", DW'(we_q[0].a), DW'(19'h00020));
            check("chg_first_mask", DW'(we_q[0].m), DW'(16'h8000));
            check("chg_second_addr", DW'(we_q[1].a), DW'(19'h00030));
            check("chg_second_mask", DW'(we_q[1].m), DW'(16'h8000));
            check("chg_second_data", we_q[1].d, 128'h22 << 120);
            check("chg_second_latency", DW'(we_q[1].c - t1), DW'(17));
        end

        we_q.delete();
        write_byte(19'h00045, 8'h33, t0, s);
        write_byte(19'h00045, 8'h44, t1, s);
        pulse_flush(fc);
        idle(FT + 4);
        check("rw_we_count", DW'(we_q.size()), DW'(1));
        if (we_q.size() > 0) begin
            check("rw_latency", DW'(we_q[0].c - fc), DW'(1));
            check("rw_mask", DW'(we_q[0].m), DW'(16'h0400));
            check("rw_data", we_q[0].d, 128'h44 << 80);
        end

        we_q.delete();
        pulse_flush(fc);
        idle(4);
        check("idle_flush_we_count", DW'(we_q.size()), DW'(0));
        write_byte(19'h00001, 8'h5A, t0, s);
        pulse_flush(fc);
        idle(4);
        check("flush_we_count", DW'(we_q.size()), DW'(1));
        if (we_q.size() > 0) begin
            check("flush_latency", DW'(we_q[0].c - fc), DW'(1));
            check("flush_mask", DW'(we_q[0].m), DW'(16'h4000));
            check("flush_data", we_q[0].d, 128'h5A << 112);
        end

        we_q.delete();
        write_byte(19'h00007, 8'h77, t0, s);
        idle(2);
        RESET_n = 1'b0;
        @(negedge CLK);
        check("mid_rst_we", DW'(WE), DW'(0));
        check("mid_rst_busy", DW'(BUSY), DW'(0));
        check("mid_rst_addr", DW'(ADDR_OUT), DW'(0));
        check("mid_rst_data", DATA_OUT, DW'(0));
        check("mid_rst_mask", DW'(WMASK_OUT), DW'(0));
        @(posedge CLK);
        #1;
        idle(2);
        RESET_n = 1'b1;
        idle(FT + 8);
        check("mid_rst_no_write", DW'(we_q.size()), DW'(0));

        timeout_case("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
